// File: rtl/entity_file_arbiter.sv
// ---------------------------------------------------------------------------
// entity_file_arbiter
//
// Request/grant arbiter in front of the entity file address and write-enable
// ports. NUM_CH subsystems (sprite, position, collision, ...) request access.
// Exactly one of them owns the port at a time. A dead cycle follows every
// release, so ownership never changes back-to-back while a write is live.
//
// Parameters
//   NUM_CH    number of requesting channels (2..8)
//   ADDR_W    entity file address width
//   WE_MASK   bit i = 1 lets channel i write (channel 0 read-only by default)
//   LOCK_MAX  grant cycles before a forced release when others wait
//             (0 = unlimited)
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_mode       0 = fixed priority (lowest index), 1 = round-robin
//   i_req        per-channel level request, held until done
//   i_ch_addr    channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   i_ch_we      per-channel write enable
//   o_gnt        registered one-hot grant, all-zero when idle
//   o_gnt_id     index of the granted channel, 0 when idle
//   o_busy       registered, high while a grant is active
//   o_mux_addr   address presented to the entity file
//   o_mux_we     write enable presented to the entity file
// ---------------------------------------------------------------------------
module entity_file_arbiter #(
  parameter int                NUM_CH   = 2,
  parameter int                ADDR_W   = 2,
  parameter logic [NUM_CH-1:0] WE_MASK  = NUM_CH'(2'b10),
  parameter int                LOCK_MAX = 4,
  localparam int               ID_W     = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_mode,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [NUM_CH-1:0]        i_ch_we,
  output logic [NUM_CH-1:0]        o_gnt,
  output logic [ID_W-1:0]          o_gnt_id,
  output logic                     o_busy,
  output logic [ADDR_W-1:0]        o_mux_addr,
  output logic                     o_mux_we
);

  // The hold counter only needs to reach LOCK_MAX; with LOCK_MAX = 0 it is
  // loaded on grant and otherwise unused.
  localparam int              CNT_W    = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_MAX);
  localparam logic [ID_W-1:0]  LAST_CH  = ID_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_gnt;
  logic [ID_W-1:0]   r_gnt_id;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_rr_ptr;

  state_t            w_state_nxt;
  logic [NUM_CH-1:0] w_gnt_nxt;
  logic [ID_W-1:0]   w_gnt_id_nxt;
  logic              w_busy_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ID_W-1:0]   w_rr_ptr_nxt;

  logic              w_any_req;
  logic [ID_W-1:0]   w_fp_id;
  logic [ID_W-1:0]   w_rr_id;
  logic [ID_W-1:0]   w_win_id;
  logic              w_holder_req;
  logic              w_others_req;
  logic              w_force;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    w_fp_id = '0;
    w_rr_id = '0;
    idx     = 0;

    // Fixed priority: scan from the top so the lowest requester is written
    // last and wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_req[i]) w_fp_id = ID_W'(i);
    end

    // Round-robin: offsets NUM_CH..1 past the pointer, scanned downwards so
    // the nearest requester after rr_ptr wins. Offset NUM_CH is the pointer
    // itself, which is only chosen when it is the sole requester.
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (i_req[idx]) w_rr_id = ID_W'(idx);
    end
  end

  assign w_any_req    = |i_req;
  assign w_win_id     = i_mode ? w_rr_id : w_fp_id;
  assign w_holder_req = |(i_req & r_gnt);
  assign w_others_req = |(i_req & ~r_gnt);
  assign w_force      = (LOCK_MAX != 0) && (r_cnt >= LOCK_VAL) && w_others_req;

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_busy_nxt   = r_busy;
    w_cnt_nxt    = r_cnt;
    w_rr_ptr_nxt = r_rr_ptr;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = NUM_CH'(1) << w_win_id;
          w_gnt_id_nxt = w_win_id;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = CNT_W'(1);
          w_rr_ptr_nxt = w_win_id;
        end
      end

      S_GRANT: begin
        if (!w_holder_req || w_force) begin
          w_state_nxt  = S_GAP;
          w_gnt_nxt    = '0;
          w_gnt_id_nxt = '0;
          w_busy_nxt   = 1'b0;
          w_cnt_nxt    = '0;
        end else if ((LOCK_MAX != 0) && (r_cnt < LOCK_VAL)) begin
          // Saturates at LOCK_MAX; a lone requester keeps the port.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        // Mode changes and pending requests are only looked at in IDLE.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        w_busy_nxt   = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      // Pointer at the last channel so channel 0 wins the first round-robin.
      r_rr_ptr <= LAST_CH;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_busy   <= w_busy_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath mux
  // -------------------------------------------------------------------------
  // Selected from the one-hot grant so no index can reach past NUM_CH-1.
  // The state register resets asynchronously, so the mux drops to zero the
  // moment reset is asserted, without waiting for a clock edge.
  always_comb begin
    o_mux_addr = '0;
    o_mux_we   = 1'b0;
    if (r_state == S_GRANT) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_gnt[i]) begin
          o_mux_addr = i_ch_addr[i*ADDR_W +: ADDR_W];
          o_mux_we   = i_ch_we[i] & WE_MASK[i];
        end
      end
    end
  end

  assign o_gnt    = r_gnt;
  assign o_gnt_id = r_gnt_id;
  assign o_busy   = r_busy;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_gnt_onehot : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0(r_gnt));
  a_busy_gnt   : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    r_busy == (|r_gnt));

endmodule

// File: doc/entity_file_arbiter.md
# entity_file_arbiter

Parametrised arbiter in front of the entity file's address and write-enable ports. It replaces the two-way, FSM-steered select with a request/grant scheme for NUM_CH subsystems (sprite, position, collision, …). It supports fixed-priority and round-robin modes, a per-channel write-permission mask, and a bounded grant hold time. It sits between the subsystem FSMs and the entity file; the entity file sees exactly one address/WE source per cycle.

## Interface
- NUM_CH, 2: number of requesting channels, 2..8
- ADDR_W, 2: entity file address width
- WE_MASK, NUM_CH'b10: bit i = 1 lets channel i write; channel 0 (sprite) is read-only by default
- LOCK_MAX, 4: grant cycles before forced release when others wait; 0 = unlimited
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- MODE  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- REQ  in  NUM_CH  per-channel access request, level, held until done
- CH_ADDR  in  NUM_CH*ADDR_W  channel addresses, channel i at bits [i*ADDR_W +: ADDR_W]
- CH_WE  in  NUM_CH  per-channel write enable
- GNT  out  NUM_CH  registered one-hot grant, all-zero when idle
- GNT_ID  out  $clog2(NUM_CH)  index of granted channel, 0 when idle
- BUSY  out  1  registered, high while any grant is active
- MUX_ADDR  out  ADDR_W  address to entity file
- MUX_WE  out  1  write enable to entity file

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: one channel owns the port.
  - GAP: single dead cycle after every release.
- IDLE, any REQ high at the edge: pick a winner and go to GRANT. Set GNT[w], GNT_ID = w, BUSY = 1, hold counter = 1.
- Winner selection:
  - MODE 0: lowest-index requesting channel.
  - MODE 1: first requesting channel after rr_ptr, wrapping from NUM_CH-1 to 0.
  - On every grant, rr_ptr <= winner, in both modes.
- GRANT, each edge:
  - If REQ[w] is low: release and go to GAP.
  - Else if LOCK_MAX != 0, counter >= LOCK_MAX, and any other REQ is high: forced release and go to GAP.
  - Else stay in GRANT and increment the counter, saturating at LOCK_MAX.
  - A lone requester holds indefinitely.
- GAP: GNT = 0, BUSY = 0, then unconditionally go to IDLE. The gap guarantees no back-to-back owner change with WE live.
- MODE changes take effect only at the next arbitration. The current grant is not disturbed.
- Datapath (combinational from registered GNT_ID/state):
  - In GRANT: MUX_ADDR = CH_ADDR[GNT_ID] and MUX_WE = CH_WE[GNT_ID] & WE_MASK[GNT_ID].
  - Otherwise: MUX_ADDR = 0 and MUX_WE = 0.
- CH_WE from a channel without a grant is ignored.
- Reset (any time, including mid-grant): state IDLE, GNT = 0, GNT_ID = 0, BUSY = 0, counter = 0, rr_ptr = NUM_CH-1 so channel 0 wins first in round-robin. MUX_ADDR = 0 and MUX_WE = 0 immediately, asynchronously.

## Timing
- Grant latency: REQ sampled high at edge k in IDLE gives GNT high after edge k. A requester may drive address/WE from the cycle after it sees GNT.
- Release: REQ low sampled at edge k gives GNT low after edge k. The earliest next grant is after edge k+2 (GAP, then IDLE arbitrates).
- Forced release occurs at the edge where counter = LOCK_MAX, so the holder gets exactly LOCK_MAX cycles of grant.
- MUX_ADDR/MUX_WE follow CH_ADDR/CH_WE combinationally during GRANT. There is no added latency.
- Simultaneous REQ drop by the holder and new REQs from others: release to GAP; the new requests are arbitrated in IDLE.

## Test plan
- Reset: Reset_n low, then high with no REQ. GNT = 0, BUSY = 0, MUX_ADDR = 0, MUX_WE = 0 for 10 cycles.
- Single writer, NUM_CH = 2:
  - REQ = 2'b10, CH_ADDR[1] = 2'd3, CH_WE[1] = 1. GNT = 2'b10 one cycle later, MUX_ADDR = 3, MUX_WE = 1.
  - Drop REQ. GNT = 0 next cycle, with one GAP cycle.
- Write mask: only channel 0 requests, with CH_WE[0] = 1 and CH_ADDR[0] = 2'd2. GNT = 2'b01, MUX_ADDR = 2, MUX_WE = 0 throughout.
- Fixed priority vs round-robin, NUM_CH = 3:
  - All REQ held high with MODE = 0: channel 0 always wins, forced release every 4 grant cycles, then channel 0 again.
  - MODE = 1: grants rotate 0 → 1 → 2 → 0, each lasting 4 cycles with a 1-cycle gap.
- Lone holder: LOCK_MAX = 4, only channel 1 requests for 20 cycles. GNT stays 2'b10 for all 20 cycles with no forced release.
- Reset mid-grant: assert Reset_n low during a channel 1 write. MUX_WE falls to 0 in the same cycle, without waiting for a clock edge. After release, the first round-robin grant goes to channel 0.
